lsu: RTL and testbench

Load/store unit between the core's execute stage and `datamem`. Turns byte addresses and RISC-V funct3 into word addresses, byte masks and lane-shifted store data for `datamem`, and extracts and sign/zero-extends load data from it. Misaligned halfword and word accesses that cross a word boundary are split into two consecutive `datamem` accesses by a small FSM, which stalls the core for one cycle.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_if.sv | 36 +++
 rtl/lsu_load_extend.sv | 21 ++
 rtl/lsu.sv | 123 ++++++++++++
 tb/tb_lsu.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W = 8;
  localparam int unsigned XLEN       = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } lsu_state_t;

  // One datamem beat, excluding the word address whose width is a parameter.
  typedef struct packed {
    logic            load;
    logic            store;
    logic [3:0]      mask;
    logic [XLEN-1:0] data;
  } dm_beat_t;

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic f3_reserved(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and datamem-side signals of the load/store unit.
interface lsu_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W
);

  logic              mem_read;
  logic              mem_write;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;
  logic              stall;
  logic              access_err;
  logic              dm_load;
  logic              dm_store;
  logic [ADDR_W-1:0] dm_address;
  logic [XLEN-1:0]   dm_data_in;
  logic [3:0]        dm_masking;
  logic [XLEN-1:0]   dm_data_out;

  // Environment side: core requests plus the datamem read port.
  modport master (
    output mem_read, mem_write, funct3, addr, wdata, dm_data_out,
    input  rdata, stall, access_err, dm_load, dm_store, dm_address,
           dm_data_in, dm_masking
  );

  modport slave (
    input  mem_read, mem_write, funct3, addr, wdata, dm_data_out,
    output rdata, stall, access_err, dm_load, dm_store, dm_address,
           dm_data_in, dm_masking
  );

endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of a right-justified load word according to funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] i_word,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_result_c
);

  always_comb begin
    o_result_c = i_word;
    case (i_funct3)
      F3_B:    o_result_c = {{24{i_word[7]}}, i_word[7:0]};
      F3_H:    o_result_c = {{16{i_word[15]}}, i_word[15:0]};
      F3_BU:   o_result_c = {24'h0, i_word[7:0]};
      F3_HU:   o_result_c = {16'h0, i_word[15:0]};
      default: o_result_c = i_word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: byte-lane steering for datamem, load extension and a
// two-beat split of accesses that straddle a word boundary.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W
)(
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  lsu_state_t        r_state;
  lsu_state_t        w_state_nxt;
  logic [XLEN-1:0]   r_lo_q;
  logic [XLEN-1:0]   w_lo_nxt;

  logic [1:0]        w_off;
  logic [ADDR_W-1:0] w_widx;
  logic              w_req;
  logic              w_err;
  logic              w_go;
  logic [6:0]        w_fm;
  logic              w_split;
  logic [4:0]        w_sh_lo;
  logic [4:0]        w_sh_hi;
  logic [XLEN-1:0]   w_lo_word;
  logic [XLEN-1:0]   w_merged;
  logic [XLEN-1:0]   w_ext_in;
  logic [XLEN-1:0]   w_ext_out;
  dm_beat_t          w_beat;
  logic              w_unused;

  assign w_off    = bus.addr[1:0];
  assign w_widx   = bus.addr[ADDR_W+1:2];
  assign w_unused = ^bus.addr[XLEN-1:ADDR_W+2];

  assign w_req = bus.mem_read | bus.mem_write;
  assign w_err = w_req & ((bus.mem_read & bus.mem_write) |
                          f3_reserved(bus.funct3) |
                          (bus.mem_write & bus.funct3[2]));
  assign w_go  = w_req & ~w_err;

  // Bytes beyond lane 3 belong to the next word.
  assign w_fm    = 7'(size_mask(bus.funct3)) << w_off;
  assign w_split = |w_fm[6:4];

  // Shift amounts: 8*off for part 1, 8*(4-off) for part 2 (off is 1..3 there).
  assign w_sh_lo = {w_off, 3'b000};
  assign w_sh_hi = {2'(3'd4 - {1'b0, w_off}), 3'b000};

  assign w_lo_word = bus.dm_data_out >> w_sh_lo;
  assign w_merged  = r_lo_q | (bus.dm_data_out << w_sh_hi);
  assign w_ext_in  = (r_state == SECOND) ? w_merged : w_lo_word;

  load_extend u_load_extend (
    .i_word     (w_ext_in),
    .i_funct3   (bus.funct3),
    .o_result_c (w_ext_out)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_lo_q  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lo_q  <= w_lo_nxt;
    end
  end

  // Next-state logic; the low part of a split load is held for the merge.
  always_comb begin
    w_state_nxt = r_state;
    w_lo_nxt    = r_lo_q;
    case (r_state)
      IDLE: begin
        if (w_go && w_split) begin
          w_state_nxt = SECOND;
          if (bus.mem_read) w_lo_nxt = w_lo_word;
        end
      end
      SECOND:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_beat         = '0;
    bus.dm_address = '0;
    bus.stall      = 1'b0;
    bus.rdata      = '0;
    bus.access_err = w_err;
    if (w_go) begin
      w_beat.load  = bus.mem_read;
      w_beat.store = bus.mem_write;
      case (r_state)
        IDLE: begin
          bus.dm_address = w_widx;
          w_beat.mask    = w_fm[3:0];
          w_beat.data    = bus.wdata << w_sh_lo;
          bus.stall      = w_split;
          if (bus.mem_read && !w_split) bus.rdata = w_ext_out;
        end
        SECOND: begin
          bus.dm_address = w_widx + ADDR_W'(1);
          w_beat.mask    = {1'b0, w_fm[6:4]};
          w_beat.data    = bus.wdata >> w_sh_hi;
          if (bus.mem_read) bus.rdata = w_ext_out;
        end
        default: ;
      endcase
    end
  end

  assign bus.dm_load    = w_beat.load;
  assign bus.dm_store   = w_beat.store;
  assign bus.dm_masking = w_beat.mask;
  assign bus.dm_data_in = w_beat.data;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu with a behavioural datamem and a byte-level reference.
module tb_lsu;
  import lsu_pkg::*;

  localparam int unsigned AW = 8;

  localparam int O_RDATA = 0;
  localparam int O_STALL = 1;
  localparam int O_ERR   = 2;
  localparam int O_LOAD  = 3;
  localparam int O_STORE = 4;
  localparam int O_ADDR  = 5;
  localparam int O_DIN   = 6;
  localparam int O_MASK  = 7;

  typedef struct {
    int          sel;
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  logic [31:0] mem [256];
  logic [7:0]  ref_mem [1024];

  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(AW)) bus ();

  lsu #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural datamem: combinational read, byte-masked write on the edge.
  always @(posedge clk) begin
    if (bus.dm_store)
      for (int b = 0; b < 4; b++)
        if (bus.dm_masking[b]) mem[bus.dm_address][8*b +: 8] <= bus.dm_data_in[8*b +: 8];
  end
  assign bus.dm_data_out = mem[bus.dm_address];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      O_RDATA: return bus.rdata;
      O_STALL: return 32'(bus.stall);
      O_ERR:   return 32'(bus.access_err);
      O_LOAD:  return 32'(bus.dm_load);
      O_STORE: return 32'(bus.dm_store);
      O_ADDR:  return 32'(bus.dm_address);
      O_DIN:   return bus.dm_data_in;
      default: return 32'(bus.dm_masking);
    endcase
  endfunction

  task automatic expect_out(input int sel, input string tag, input logic [31:0] v);
    exp_t e;
    e.sel = sel; e.tag = tag; e.val = v;
    sb.push_back(e);
  endtask

  // Compare everything expected for this cycle, then advance one clock.
  task automatic step();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.mem_read = rd; bus.mem_write = wr; bus.funct3 = f3;
    bus.addr = a; bus.wdata = wd;
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(a[9:0]) + i) % 1024];
    if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // One complete legal access (one or two cycles) checked against the reference.
  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    logic [7:0]  w0;
    logic [31:0] exp_r;
    bit          split;
    w0    = a[9:2];
    split = (int'(a[1:0]) + nbytes(f3)) > 4;
    exp_r = wr ? 32'h0 : ref_load(f3, a);
    drive(!wr, wr, f3, a, wd);
    if (split) begin
      expect_out(O_STALL, {tag, "_stall1"}, 32'd1);
      expect_out(O_ADDR,  {tag, "_addr1"},  32'(w0));
      step();
      w0 = w0 + 8'd1;
    end
    expect_out(O_STALL, {tag, "_stall"}, 32'd0);
    expect_out(O_ADDR,  {tag, "_addr"},  32'(w0));
    expect_out(O_RDATA, {tag, "_rdata"}, exp_r);
    step();
    if (wr)
      for (int i = 0; i < nbytes(f3); i++)
        ref_mem[(int'(a[9:0]) + i) % 1024] = wd[8*i +: 8];
    drive(1'b0, 1'b0, F3_B, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1;
    drive(1'b0, 1'b0, F3_B, 32'h0, 32'h0);
    #1;
    expect_out(O_STALL, "rst_stall", 32'd0);
    expect_out(O_RDATA, "rst_rdata", 32'd0);
    expect_out(O_ERR,   "rst_err",   32'd0);
    expect_out(O_LOAD,  "rst_load",  32'd0);
    expect_out(O_STORE, "rst_store", 32'd0);
    expect_out(O_MASK,  "rst_mask",  32'd0);
    step();
    rst = 1'b0;

    // Aligned word store and load
    drive(1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    expect_out(O_MASK, "sw_mask", 32'hF);  expect_out(O_ADDR, "sw_addr", 32'd4);
    expect_out(O_STALL, "sw_stall", 32'd0); expect_out(O_STORE, "sw_store", 32'd1);
    expect_out(O_DIN, "sw_din", 32'hDEADBEEF);
    step();
    drive(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
    expect_out(O_MASK, "lw_mask", 32'hF); expect_out(O_ADDR, "lw_addr", 32'd4);
    expect_out(O_LOAD, "lw_load", 32'd1); expect_out(O_RDATA, "lw_rdata", 32'hDEADBEEF);
    step();

    // Byte lane 3
    drive(1'b0, 1'b1, F3_B, 32'h13, 32'h000000A5);
    expect_out(O_MASK, "sb_mask", 32'h8); expect_out(O_DIN, "sb_din", 32'hA5000000);
    step();
    drive(1'b1, 1'b0, F3_B, 32'h13, 32'h0);
    expect_out(O_RDATA, "lb_rdata", 32'hFFFFFFA5);
    step();
    drive(1'b1, 1'b0, F3_BU, 32'h13, 32'h0);
    expect_out(O_RDATA, "lbu_rdata", 32'h000000A5);
    step();

    // Split word store at 0x0E
    drive(1'b0, 1'b1, F3_W, 32'h0E, 32'h11223344);
    expect_out(O_ADDR, "ssw_addr1", 32'd3); expect_out(O_MASK, "ssw_mask1", 32'hC);
    expect_out(O_STALL, "ssw_stall1", 32'd1); expect_out(O_DIN, "ssw_din1", 32'h33440000);
    step();
    expect_out(O_ADDR, "ssw_addr2", 32'd4); expect_out(O_MASK, "ssw_mask2", 32'h3);
    expect_out(O_STALL, "ssw_stall2", 32'd0); expect_out(O_DIN, "ssw_din2", 32'h00001122);
    step();
    drive(1'b1, 1'b0, F3_W, 32'h0E, 32'h0);
    expect_out(O_STALL, "slw_stall1", 32'd1); expect_out(O_RDATA, "slw_rdata1", 32'h0);
    step();
    expect_out(O_STALL, "slw_stall2", 32'd0); expect_out(O_RDATA, "slw_rdata2", 32'h11223344);
    step();
    drive(1'b1, 1'b0, F3_H, 32'h0F, 32'h0);
    step();
    expect_out(O_RDATA, "slh_rdata", 32'h00002233);
    step();

    // Halfword at the top of memory wraps to word 0
    drive(1'b0, 1'b1, F3_H, 32'h3FF, 32'h0000BEEF);
    expect_out(O_ADDR, "wsh_addr1", 32'd255); expect_out(O_MASK, "wsh_mask1", 32'h8);
    expect_out(O_DIN, "wsh_din1", 32'hEF000000);
    step();
    expect_out(O_ADDR, "wsh_addr2", 32'd0); expect_out(O_MASK, "wsh_mask2", 32'h1);
    expect_out(O_DIN, "wsh_din2", 32'h000000BE);
    step();
    drive(1'b1, 1'b0, F3_HU, 32'h3FF, 32'h0);
    step();
    expect_out(O_RDATA, "wlhu_rdata", 32'h0000BEEF);
    step();
    drive(1'b1, 1'b0, F3_H, 32'h3FF, 32'h0);
    step();
    expect_out(O_RDATA, "wlh_rdata", 32'hFFFFBEEF);
    step();

    // Illegal requests
    drive(1'b1, 1'b1, F3_W, 32'h20, 32'h12345678);
    expect_out(O_ERR, "rw_err", 32'd1); expect_out(O_STORE, "rw_store", 32'd0);
    expect_out(O_LOAD, "rw_load", 32'd0); expect_out(O_RDATA, "rw_rdata", 32'd0);
    expect_out(O_STALL, "rw_stall", 32'd0);
    step();
    check_eq("rw_mem", mem[8], 32'h0);
    drive(1'b0, 1'b1, F3_BU, 32'h24, 32'h000000FF);
    expect_out(O_ERR, "sbu_err", 32'd1); expect_out(O_STORE, "sbu_store", 32'd0);
    step();
    check_eq("sbu_mem", mem[9], 32'h0);
    drive(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    expect_out(O_ERR, "f3_err", 32'd1); expect_out(O_LOAD, "f3_load", 32'd0);
    expect_out(O_RDATA, "f3_rdata", 32'd0);
    step();
    drive(1'b0, 1'b0, F3_W, 32'h10, 32'h0);
    expect_out(O_ERR, "idle_err", 32'd0); expect_out(O_ADDR, "idle_addr", 32'd0);
    step();

    // Reset in the first cycle of a split store
    drive(1'b0, 1'b1, F3_W, 32'h2E, 32'h11223344);
    expect_out(O_STALL, "rsp_stall1", 32'd1); expect_out(O_ADDR, "rsp_addr1", 32'd11);
    @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.val);
    end
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
    expect_out(O_STALL, "rsp_stall", 32'd0); expect_out(O_ADDR, "rsp_addr", 32'd4);
    expect_out(O_RDATA, "rsp_rdata", 32'hA5AD1122);
    step();
    drive(1'b0, 1'b0, F3_B, 32'h0, 32'h0);
    step();
    check_eq("rsp_part1", mem[11], 32'h33440000);
    check_eq("rsp_part2", mem[12], 32'h0);

    // Random mix against the byte-level reference
    for (int w = 0; w < 256; w++)
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = mem[w][8*b +: 8];
    for (int k = 0; k < 80; k++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic        wr;
      int          pick;
      wr   = ($urandom_range(0, 1) == 1);
      pick = wr ? $urandom_range(0, 2) : $urandom_range(0, 4);
      case (pick)
        0: f3 = F3_B;
        1: f3 = F3_H;
        2: f3 = F3_W;
        3: f3 = F3_BU;
        default: f3 = F3_HU;
      endcase
      a  = $urandom() & 32'h0000_03FF;
      if (k % 4 == 0) a = a | 32'h0000_0003;
      wd = $urandom();
      access(wr, f3, a, wd, $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
